// File: rtl/tcs_filter_sequencer.sv
// Control sequencer for a TCS3200-style colour sensor: steps the R/G/B/C filters,
// counts frequency-output edges per filter and publishes the four counts together.
module tcs_filter_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned CNT_W         = 32,
    parameter logic [1:0]  SCALE         = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             freq_in,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             oe_n,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        STORE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B,
        CH_C
    } chan_t;

    state_t             state_q, state_d;
    chan_t              chan_q, chan_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         scale_d;
    logic [1:0]         code_d;
    logic               oe_n_d;
    logic               busy_d;

    logic               sync1_q, sync2_q, sync3_q;
    logic               edge_c;
    logic [CNT_W-1:0]   edge_cnt_q;
    logic [CNT_W-1:0]   shadow_q [4];

    assign edge_c = sync2_q & ~sync3_q;

    // State, channel and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= CH_R;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            timer_q <= timer_d;
        end
    end

    // Next state plus next pin values; pins are registered so they align with the state
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        timer_d = timer_q;
        scale_d = 2'b00;
        code_d  = 2'b00;
        oe_n_d  = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    chan_d  = CH_R;
                    timer_d = '0;
                end
            end
            SETTLE: begin
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = GATE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            GATE: begin
                if (timer_q == TMR_W'(GATE_CYCLES - 1)) begin
                    state_d = STORE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            STORE: begin
                timer_d = '0;
                if (chan_q == CH_C) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    chan_d  = chan_t'(2'(chan_q) + 2'd1);
                end
            end
            DONE: begin
                timer_d = '0;
                if (continuous) begin
                    state_d = SETTLE;
                    chan_d  = CH_R;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                chan_d  = CH_R;
                timer_d = '0;
            end
        endcase

        if (state_d != IDLE) begin
            scale_d = SCALE;
            oe_n_d  = 1'b0;
            busy_d  = 1'b1;
            case (chan_d)
                CH_R:    code_d = 2'b00;
                CH_G:    code_d = 2'b11;
                CH_B:    code_d = 2'b01;
                default: code_d = 2'b10;
            endcase
        end
    end

    // Registered sensor pins and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            oe_n <= 1'b1;
            busy <= 1'b0;
        end else begin
            {s0, s1} <= scale_d;
            {s2, s3} <= code_d;
            oe_n     <= oe_n_d;
            busy     <= busy_d;
        end
    end

    // freq_in synchroniser plus edge-detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= freq_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Saturating edge counter, live only during the gate window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
        end else if (state_q == IDLE || state_q == SETTLE) begin
            edge_cnt_q <= '0;
        end else if (state_q == GATE && edge_c && edge_cnt_q != {CNT_W{1'b1}}) begin
            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
        end
    end

    // Per-channel shadows, published together one cycle after DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
            clear_cnt <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state_q == STORE) begin
                shadow_q[chan_q] <= edge_cnt_q;
            end
            if (state_q == DONE) begin
                red_cnt   <= shadow_q[0];
                green_cnt <= shadow_q[1];
                blue_cnt  <= shadow_q[2];
                clear_cnt <= shadow_q[3];
                valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcs_filter_sequencer.sv
// Randomised scoreboard bench for tcs_filter_sequencer with a sweep-timeline reference
// model and a period-programmable sensor model; a second narrow instance covers saturation.
module tb_tcs_filter_sequencer;

    localparam int SETTLE = 4;
    localparam int GATE   = 20;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 3;
    localparam int CHAN   = SETTLE + GATE + 1;
    localparam int SWEEP  = 4 * CHAN;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             continuous;
    logic             freq_in;
    logic             s0, s1, s2, s3, oe_n, valid, busy;
    logic [CNT_W-1:0] red_cnt, green_cnt, blue_cnt, clear_cnt;

    logic             start2;
    logic             freq2;
    logic             t0, t1, t2, t3, oe2_n, valid2, busy2;
    logic [SAT_W-1:0] red2, green2, blue2, clear2;

    tcs_filter_sequencer #(
        .SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(CNT_W), .SCALE(2'b10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .freq_in(freq_in),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .oe_n(oe_n),
        .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt), .clear_cnt(clear_cnt),
        .valid(valid), .busy(busy)
    );

    tcs_filter_sequencer #(
        .SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(SAT_W), .SCALE(2'b10)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .continuous(1'b0), .freq_in(freq2),
        .s0(t0), .s1(t1), .s2(t2), .s3(t3), .oe_n(oe2_n),
        .red_cnt(red2), .green_cnt(green2), .blue_cnt(blue2), .clear_cnt(clear2),
        .valid(valid2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt[4];
    } exp_t;

    exp_t       sb[$];
    int         vectors    = 0;
    int         miscompares = 0;
    int         per[4];
    int         cyc        = 0;
    int         t          = -1;
    int         pub[4];
    int         nvalid     = 0;
    logic [1:0] codes[4]   = '{2'b00, 2'b11, 2'b01, 2'b10};
    int         options[6] = '{0, 2, 4, 5, 10, 20};

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Edges per gate window for a sensor of period p (0 = edges only while settling)
    function automatic int exp_count(input int p, input int w);
        int n;
        int maxv;
        n    = (p == 0) ? 0 : GATE / p;
        maxv = (1 << w) - 1;
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic int chan_of(input logic [1:0] code);
        case (code)
            2'b00:   return 0;
            2'b11:   return 1;
            2'b01:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic begin_sweep();
        exp_t e;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            per[i] = options[$urandom_range(0, 5)];
            e.cnt[i] = exp_count(per[i], CNT_W);
        end
        e.cyc = cyc + SWEEP + 1;
        sb.push_back(e);
    endtask

    // Reference model: position t within the sweep timeline (-1 = idle)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = -1;
            sb.delete();
        end else begin
            cyc++;
            if (t < 0) begin
                if (start) begin_sweep();
            end else if (t == SWEEP) begin
                if (continuous) begin_sweep();
                else t = -1;
            end else begin
                t++;
            end
        end
    end

    // Sensor model: restarts its phase whenever the enabled filter changes
    logic [2:0] last_key = 3'b100;
    int         ph = 0;
    always @(negedge clk) begin
        int p;
        if (oe_n) begin
            freq_in = 1'b0;
            ph      = 0;
        end else begin
            if ({oe_n, s2, s3} != last_key) ph = 0;
            else ph++;
            p = per[chan_of({s2, s3})];
            if (p == 0) freq_in = (ph == 0);
            else freq_in = ((ph % p) < (p / 2));
        end
        last_key = {oe_n, s2, s3};
    end

    always @(negedge clk) freq2 = (freq2 === 1'b1) ? 1'b0 : 1'b1;

    // Monitor: pins every cycle, scoreboard pop on valid, held counts otherwise
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pub[i] = 0;
        end
        if (t < 0) begin
            check("busy_idle", busy, 0);
            check("oe_n_idle", oe_n, 1);
            check("scale_idle", {s0, s1}, 2'b00);
        end else begin
            check("busy_active", busy, 1);
            check("oe_n_active", oe_n, 0);
            check("scale_active", {s0, s1}, 2'b10);
            if (t < SWEEP) check("filter_code", {s2, s3}, codes[t / CHAN]);
        end
        if (valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("valid_cycle", cyc, e.cyc);
                for (int i = 0; i < 4; i++) pub[i] = e.cnt[i];
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missing_valid", 0, 1);
            void'(sb.pop_front());
        end
        check("red_cnt", red_cnt, pub[0]);
        check("green_cnt", green_cnt, pub[1]);
        check("blue_cnt", blue_cnt, pub[2]);
        check("clear_cnt", clear_cnt, pub[3]);
    end

    initial begin
        int waited;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        start2     = 1'b0;
        for (int i = 0; i < 4; i++) per[i] = 2;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single sweep, then a sweep interrupted by reset in its first gate window
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (SWEEP + 10) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (SWEEP + 10) @(posedge clk);

        // Random start pulses, continuous toggling and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst_n = ($urandom_range(0, 799) != 0);
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) continuous = ~continuous;
        end
        @(posedge clk); #2;
        rst_n      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (2 * SWEEP + 10) @(posedge clk);
        @(negedge clk);
        check("pending_valid", sb.size(), 0);
        check("valid_seen", (nvalid >= 5), 1);

        // Saturation on the narrow instance: period-2 input on every filter
        @(posedge clk); #2 start2 = 1'b1;
        @(posedge clk); #2 start2 = 1'b0;
        waited = 0;
        while (valid2 !== 1'b1 && waited < 3 * SWEEP) begin
            @(negedge clk);
            waited++;
        end
        if (valid2 !== 1'b1) begin
            check("sat_timeout", 0, 1);
        end else begin
            check("sat_red", red2, exp_count(2, SAT_W));
            check("sat_green", green2, exp_count(2, SAT_W));
            check("sat_blue", blue2, exp_count(2, SAT_W));
            check("sat_clear", clear2, exp_count(2, SAT_W));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
